// File: rtl/fp_op_dispatcher.sv
// fp_op_dispatcher: command FIFO + issue FSM in front of the FP add/sub unit.
// Ports: clk/rst, in_* (cmd valid/ready), fp_* (adder side),
//        out_* (result valid/ready), count (FIFO occupancy), busy.
module fp_op_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_op,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       fp_start,
    output logic                       fp_op,
    output logic [31:0]                fp_a,
    output logic [31:0]                fp_b,
    input  logic                       fp_ready,
    input  logic [31:0]                fp_c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = $clog2(TIMEOUT+1);
    localparam int EW = 1 + 32 + 32 + TAG_W;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_OUTPUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [EW-1:0]    head;
    logic [TAG_W-1:0] hold_tag;
    logic [WW-1:0]    wd;

    logic push;
    logic pop;
    logic waiting;
    logic wd_hit;
    logic cap_ok;
    logic abort;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (state == S_IDLE) & (count != '0) & fp_ready;
    assign head     = mem[rd_ptr];

    assign waiting = (state == S_WAIT_LOW) | (state == S_WAIT_HIGH);
    assign wd_hit  = (wd == WW'(TIMEOUT-1));
    assign cap_ok  = (state == S_WAIT_HIGH) & fp_ready;
    // A real completion on the last allowed cycle beats the abort.
    assign abort   = waiting & wd_hit & ~cap_ok;

    // FIFO storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_a, in_b, in_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (pop) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                state_nx = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (abort)          state_nx = S_OUTPUT;
                else if (!fp_ready) state_nx = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (cap_ok | abort) state_nx = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        fp_start  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_ISSUE:  fp_start  = 1'b1;
            S_OUTPUT: out_valid = 1'b1;
            default: ;
        endcase
        busy = (state != S_IDLE) | (count != '0);
    end

    // Watchdog: cleared on issue, counts only while waiting on the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (state == S_ISSUE) begin
            wd <= '0;
        end else if (waiting & ~wd_hit) begin
            wd <= wd + WW'(1);
        end
    end

    // Operands stay put from issue until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp_op    <= 1'b0;
            fp_a     <= '0;
            fp_b     <= '0;
            hold_tag <= '0;
        end else if (pop) begin
            fp_op    <= head[EW-1];
            fp_a     <= head[EW-2 -: 32];
            fp_b     <= head[EW-34 -: 32];
            hold_tag <= head[TAG_W-1:0];
        end
    end

    // Result slot: only written when entering OUTPUT, so it is stable
    // for as long as the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else if (cap_ok) begin
            out_result <= fp_c;
            out_tag    <= hold_tag;
            out_err    <= 1'b0;
        end else if (abort) begin
            out_result <= QNAN;
            out_tag    <= hold_tag;
            out_err    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_op_dispatcher.sv
// tb_fp_op_dispatcher: vector table, corner sequences and random traffic
// against an adder model (C = A xor B) and a queue-based reference.
module tb_fp_op_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              fp_start;
    logic              fp_op;
    logic [31:0]       fp_a;
    logic [31:0]       fp_b;
    logic              fp_ready;
    logic [31:0]       fp_c;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic [2:0]        count;
    logic              busy;

    fp_op_dispatcher #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .fp_start(fp_start), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
        .fp_ready(fp_ready), .fp_c(fp_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Adder model. mode 0: fixed 3-edge busy, 1: hangs low,
    // 2: never drops ready, 3: random 1..5 edge busy.
    int          mode = 0;
    logic        mdl_rdy = 1'b1;
    int          mdl_cnt = 0;
    logic [31:0] mdl_c = '0;
    logic [31:0] lat_a = '0;
    logic [31:0] lat_b = '0;
    logic        lat_op = 1'b0;

    assign fp_ready = mdl_rdy;
    assign fp_c     = mdl_c;

    always @(posedge clk) begin
        if (fp_start) begin
            lat_a  <= fp_a;
            lat_b  <= fp_b;
            lat_op <= fp_op;
            mdl_c  <= fp_a ^ fp_b;
            if (mode != 2) begin
                mdl_rdy <= 1'b0;
                mdl_cnt <= (mode == 3) ? int'($urandom_range(1, 5)) : 3;
            end
        end else if (!mdl_rdy && mode != 1) begin
            if (mdl_cnt <= 1) mdl_rdy <= 1'b1;
            else              mdl_cnt <= mdl_cnt - 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic acc;
        logic ok;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        ok       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    // Edges from now until out_valid is seen; -1 if the bound expires.
    task automatic wait_out(input int limit, output int lat, output int starts);
        lat    = -1;
        starts = 0;
        for (int e = 1; e <= limit; e++) begin
            tick();
            if (fp_start) starts++;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
    endtask

    typedef struct {
        logic             op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } vec_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } exp_t;

    vec_t vecs [6];
    exp_t q [$];

    initial begin
        int          lat;
        int          starts;
        int          bad;
        int          seen_v;
        int          seen_s;
        int          seq;
        logic [31:0] h_res;
        logic [3:0]  h_tag;
        logic        h_err;
        logic        held;
        logic        acc_in;
        logic        acc_out;
        exp_t        e;

        vecs[0] = '{1'b0, 32'h3F80_0000, 32'h4000_0000, 4'h5, 32'h7F80_0000};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF};
        vecs[2] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 4'hF, 32'h9551_1559};
        vecs[3] = '{1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 4'hA, 32'hFFFF_FFFF};
        vecs[4] = '{1'b0, 32'hC049_0FDB, 32'hC049_0FDB, 4'h3, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_0001, 32'h8000_0000, 4'h9, 32'h8000_0001};

        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_fp_start", fp_start, 0);
        chk("rst_fp_op", fp_op, 0);
        chk("rst_fp_a", fp_a, 0);
        chk("rst_fp_b", fp_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        tick();

        // Vector table: single ops through an idle pipeline
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_out(40, lat, starts);
            chk("vec_latency", lat, 6);
            chk("vec_start_pulses", starts, 1);
            chk("vec_result", out_result, vecs[i].res);
            chk("vec_tag", out_tag, vecs[i].tag);
            chk("vec_err", out_err, 0);
            chk("vec_op_to_adder", lat_op, vecs[i].op);
            chk("vec_fp_a_held", fp_a, vecs[i].a);
            chk("vec_fp_b_held", fp_b, vecs[i].b);
            tick();
            chk("vec_out_cleared", out_valid, 0);
        end

        // Fill with a stalled consumer, then backpressure, then drain
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++)
            push(1'b0, 32'hA5A5_0000 | t, 32'h0000_FF00, TAG_W'(t));
        wait_out(40, lat, starts);
        chk("fill_out_valid", out_valid, 1);
        chk("fill_count_full", count, DEPTH);
        chk("fill_in_ready_low", in_ready, 0);
        h_res  = out_result;
        h_tag  = out_tag;
        h_err  = out_err;
        bad    = 0;
        seen_s = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fp_start) seen_s++;
            if (!out_valid || out_result !== h_res || out_tag !== h_tag ||
                out_err !== h_err) bad++;
        end
        chk("bp_stable_cycles_bad", bad, 0);
        chk("bp_no_start", seen_s, 0);
        chk("bp_count_held", count, DEPTH);
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (!out_valid) wait_out(40, lat, starts);
            chk("drain_valid", out_valid, 1);
            chk("drain_tag", out_tag, t);
            chk("drain_result", out_result, (32'hA5A5_0000 | t) ^ 32'h0000_FF00);
            chk("drain_err", out_err, 0);
            tick();
        end
        chk("drain_busy", busy, 0);

        // Watchdog: adder hangs low, then adder never drops ready
        for (int m = 1; m <= 2; m++) begin
            mode = m;
            push(1'b1, 32'h0102_0304, 32'h1111_1111, TAG_W'(5 + m));
            wait_out(60, lat, starts);
            chk("to_latency", lat, TIMEOUT + 2);
            chk("to_result", out_result, QNAN);
            chk("to_err", out_err, 1);
            chk("to_tag", out_tag, 5 + m);
            tick();
            mode = 0;
            push(1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'hC);
            wait_out(60, lat, starts);
            chk("to_next_valid", out_valid, 1);
            chk("to_next_result", out_result, 32'hFFFF_FFFF);
            chk("to_next_err", out_err, 0);
            chk("to_next_tag", out_tag, 4'hC);
            tick();
        end

        // Reset while waiting on the adder with 2 commands queued
        push(1'b1, 32'h1, 32'h2, 4'h1);
        push(1'b1, 32'h3, 32'h4, 4'h2);
        push(1'b1, 32'h5, 32'h6, 4'h3);
        tick();
        chk("mid_count_queued", count, 2);
        chk("mid_adder_busy", fp_ready, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_fp_a", fp_a, 0);
        chk("mid_rst_fp_b", fp_b, 0);
        chk("mid_rst_fp_op", fp_op, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_result", out_result, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        seen_v = 0;
        seen_s = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (out_valid) seen_v++;
            if (fp_start) seen_s++;
        end
        chk("post_rst_no_output", seen_v, 0);
        chk("post_rst_no_issue", seen_s, 0);
        chk("post_rst_count", count, 0);

        // Random traffic against a FIFO-order reference
        mode = 3;
        seq  = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!mdl_rdy) begin
                chk("rnd_fp_a_hold", fp_a, lat_a);
                chk("rnd_fp_b_hold", fp_b, lat_b);
            end
            if (held) begin
                chk("rnd_stall_valid", out_valid, 1);
                chk("rnd_stall_result", out_result, h_res);
                chk("rnd_stall_tag", out_tag, h_tag);
            end
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 1'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
            in_tag    = TAG_W'(seq);
            out_ready = ($urandom_range(0, 3) != 0);
            acc_in    = in_valid & in_ready;
            acc_out   = out_valid & out_ready;
            if (acc_out) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_tag", out_tag, e.tag);
                    chk("rnd_result", out_result, e.res);
                    chk("rnd_err", out_err, 0);
                end
            end
            if (acc_in) begin
                q.push_back('{in_tag, in_a ^ in_b});
                seq++;
            end
            held  = out_valid & ~out_ready;
            h_res = out_result;
            h_tag = out_tag;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && q.size() != 0; cyc++) begin
            if (out_valid) begin
                e = q.pop_front();
                chk("drn_tag", out_tag, e.tag);
                chk("drn_result", out_result, e.res);
                chk("drn_err", out_err, 0);
            end
            tick();
        end
        chk("rnd_all_delivered", q.size(), 0);
        chk("rnd_idle_at_end", busy, 0);
        chk("rnd_some_traffic", seq > 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_op_dispatcher.md
Name: fp_op_dispatcher

Overview:
Upstream command stage for the floating-point add/sub unit. It accepts tagged operations (op, A, B, tag) over a valid/ready interface and buffers them in a small FIFO. It issues each operation to the adder with a one-cycle start pulse and holds the operands stable, then waits for the adder's ready handshake. It captures the result and presents it with its tag on a valid/ready output. A watchdog converts a hung adder transaction into an error result.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the user tag carried alongside each operation
TIMEOUT, 16, max cycles spent in WAIT_LOW plus WAIT_HIGH before abort

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  command valid
in_ready  output  1  FIFO can accept; equals (count < DEPTH)
in_op  input  1  0 = add, 1 = subtract
in_a  input  32  IEEE754 single operand A
in_b  input  32  IEEE754 single operand B
in_tag  input  TAG_W  user tag
fp_start  output  1  one-cycle start pulse to adder
fp_op  output  1  held op to adder
fp_a  output  32  held operand A to adder
fp_b  output  32  held operand B to adder
fp_ready  input  1  adder ready
fp_c  input  32  adder result
out_valid  output  1  result valid
out_ready  input  1  result consumer ready
out_result  output  32  captured result, or 32'h7FC00000 on timeout
out_tag  output  TAG_W  tag of the result
out_err  output  1  1 = timeout abort for this result
count  output  $clog2(DEPTH+1)  FIFO occupancy
busy  output  1  (state != IDLE) or (count != 0)

Behaviour:
- Reset state: FIFO empty; count=0; state IDLE.
- Reset values: fp_start=0, fp_op=0, fp_a=0, fp_b=0, out_valid=0, out_result=0, out_tag=0, out_err=0, in_ready=1, busy=0.
- Reset mid-operation: all in-flight and buffered commands are discarded. No output is produced for them.
- Push: in_valid & in_ready at an edge writes the command at the tail and increments count.
- No push while full, even if a pop happens in the same cycle.
- Pop occurs only on the IDLE->ISSUE transition.
- Push and pop in the same cycle leave count unchanged.
- The FIFO pointers wrap modulo DEPTH.
- Operand registers fp_op/fp_a/fp_b/tag load from the FIFO head on IDLE->ISSUE. They hold until the next issue and are never changed while the adder is busy.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, OUTPUT.
  IDLE: go to ISSUE when count != 0 and fp_ready = 1; otherwise stay.
  ISSUE: fp_start = 1 (Moore, for exactly one cycle); go to WAIT_LOW. Watchdog cleared.
  WAIT_LOW: wait for fp_ready = 0, then go to WAIT_HIGH.
  WAIT_HIGH: on fp_ready = 1, capture out_result <= fp_c, out_tag, out_err <= 0; go to OUTPUT.
  OUTPUT: out_valid = 1; on out_ready go to IDLE.
- No new issue happens while a result is pending; the single output slot backpressures the whole pipeline.
- Watchdog counts cycles in WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT:
  out_result <= 32'h7FC00000, out_err <= 1, out_tag <= held tag; go to OUTPUT.
  The same applies if fp_ready never falls after start.
- Latency, empty FIFO, adder that drops ready on the edge sampling start and raises it 3 edges after that edge: out_valid rises 6 edges after the accepting edge.
  Per-command throughput is 6 cycles plus output stall.
- out_result/out_tag/out_err are stable while out_valid = 1 and out_ready = 0.
- in_ready is independent of out_ready; commands keep buffering until the FIFO is full.

Test Plan:
- Bench uses an adder model: ready drops the edge after start, rises 3 edges later, C = A xor B (tag marker).
- Single op: push op=0, A=3F800000, B=40000000, tag=5, out_ready=1 -> fp_start high one cycle; fp_a/fp_b held until ready returns; out_valid at edge 6 with result 7F800000, tag 5, err 0.
- Fill: push 5 commands back-to-back with out_ready=0 -> in_ready low once count=4 (DEPTH=4). One result remains pending; tags drain in order 0,1,2,3,4 after out_ready=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_result/out_tag stable and no fp_start pulses; the next issue occurs only after the handshake.
- Timeout: model never raises fp_ready again -> after 16 cycles out_valid=1, out_result=7FC00000, out_err=1, correct tag; the next command then issues normally.
- Reset mid-operation: assert rst during WAIT_HIGH with 2 queued commands -> all outputs return to their reset values, count=0, and no stale result appears after release.
